led_pattern_ctrl: RTL and testbench

Sequencer for the 10-LED bar: owns the LEDR shift register and chooses which pattern drives it (bounce, chase, fill/clear, blink). It also sets the step rate from two switches and handles pause and mode-select pushbuttons. Sits at the top of the LED lab design, between the board pins (CLOCK_50, KEY, SW) and LEDR. It supersedes the fixed-rate bounce-only driver.

---
 rtl/led_pattern_ctrl_pkg.sv | 37 +++
 rtl/led_pattern_ctrl_if.sv | 16 +
 rtl/led_pattern_ctrl_key_debounce.sv | 51 +++++
 rtl/led_pattern_ctrl.sv | 136 +++++++++++++
 tb/tb_led_pattern_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/led_pattern_ctrl_pkg.sv
// Shared types and constants for the LED bar sequencer: modes, start patterns
// and the direction/phase encodings used by the pattern stepper.
package led_ctrl_pkg;

    localparam int N_LED = 10;

    typedef enum logic [1:0] {
        BOUNCE = 2'd0,
        CHASE  = 2'd1,
        FILL   = 2'd2,
        BLINK  = 2'd3
    } mode_e;

    localparam logic [N_LED-1:0] START_BOUNCE = 10'b1000000000;
    localparam logic [N_LED-1:0] START_CHASE  = 10'b0000000001;
    localparam logic [N_LED-1:0] START_FILL   = 10'b0000000000;
    localparam logic [N_LED-1:0] START_BLINK  = 10'b1111111111;

    localparam logic DIR_RIGHT   = 1'b0;
    localparam logic DIR_LEFT    = 1'b1;
    localparam logic PHASE_FILL  = 1'b0;
    localparam logic PHASE_CLEAR = 1'b1;

    function automatic mode_e next_mode(input mode_e m);
        return mode_e'(m + 2'd1);
    endfunction

    function automatic logic [N_LED-1:0] start_pattern(input mode_e m);
        case (m)
            BOUNCE:  return START_BOUNCE;
            CHASE:   return START_CHASE;
            FILL:    return START_FILL;
            default: return START_BLINK;
        endcase
    endfunction

endpackage

// File: rtl/led_pattern_ctrl_if.sv
// Board-side signal bundle of the LED sequencer: raw keys and speed switches in,
// LED bar, current mode and pause flag out. Plain levels, no handshake.
interface led_pattern_ctrl_if;
    import led_ctrl_pkg::*;

    logic             KEY_MODE;
    logic             KEY_PAUSE;
    logic [1:0]       SW;
    logic [N_LED-1:0] LEDR;
    logic [1:0]       MODE;
    logic             PAUSED;

    modport master (output KEY_MODE, KEY_PAUSE, SW, input LEDR, MODE, PAUSED);
    modport slave  (input KEY_MODE, KEY_PAUSE, SW, output LEDR, MODE, PAUSED);

endinterface

// File: rtl/led_pattern_ctrl_key_debounce.sv
// Two-flop synchronizer, level debouncer and press detector for one active-low key.
// o_press is a registered 1-cycle pulse on each accepted 1->0 debounced transition.
module key_debounce
    import led_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_press
);

    localparam int             CW       = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    // r_cnt counts consecutive cycles where the synchronized key disagrees with r_level.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 != r_level) begin
                if (r_cnt == CNT_LAST) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                    r_press <= ~r_sync2;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED bar sequencer: debounced mode/pause keys, switch-selected step rate and a
// four-mode pattern FSM driving the registered LEDR/MODE/PAUSED outputs.
module led_pattern_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int TICK_LOG2    = 24,
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic               CLOCK_50,
    input  logic               RESET_N,
    led_pattern_ctrl_if.slave  io_led
);

    mode_e                r_mode;
    logic [N_LED-1:0]     r_led;
    logic                 r_dir;
    logic                 r_phase;
    logic                 r_paused;
    logic [TICK_LOG2-1:0] r_tick_cnt;

    mode_e                w_mode_nxt;
    logic [N_LED-1:0]     w_led_nxt;
    logic                 w_dir_nxt;
    logic                 w_phase_nxt;
    logic                 w_paused_nxt;
    logic [TICK_LOG2-1:0] w_cnt_nxt;
    logic [TICK_LOG2-1:0] w_reload;
    logic [N_LED-1:0]     w_fill_shift;
    logic                 w_mode_press;
    logic                 w_pause_press;
    logic                 w_tick;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_mode (
        .i_clk   (CLOCK_50),
        .i_rst_n (RESET_N),
        .i_key_n (io_led.KEY_MODE),
        .o_press (w_mode_press)
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_pause (
        .i_clk   (CLOCK_50),
        .i_rst_n (RESET_N),
        .i_key_n (io_led.KEY_PAUSE),
        .o_press (w_pause_press)
    );

    // Period is 2^(TICK_LOG2-SW); the counter runs from period-1 down to 0.
    assign w_reload     = TICK_LOG2'((64'd1 << (TICK_LOG2 - int'(io_led.SW))) - 64'd1);
    assign w_tick       = (r_tick_cnt == '0) && !r_paused;
    assign w_fill_shift = {r_led[N_LED-2:0], ~r_phase};

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            r_mode     <= BOUNCE;
            r_led      <= START_BOUNCE;
            r_dir      <= DIR_RIGHT;
            r_phase    <= PHASE_FILL;
            r_paused   <= 1'b0;
            r_tick_cnt <= '0;
        end else begin
            r_mode     <= w_mode_nxt;
            r_led      <= w_led_nxt;
            r_dir      <= w_dir_nxt;
            r_phase    <= w_phase_nxt;
            r_paused   <= w_paused_nxt;
            r_tick_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_mode_nxt   = r_mode;
        w_led_nxt    = r_led;
        w_dir_nxt    = r_dir;
        w_phase_nxt  = r_phase;
        w_paused_nxt = r_paused;
        w_cnt_nxt    = r_tick_cnt;

        if (w_mode_press) begin
            // Mode entry overrides any tick or pause press in the same cycle.
            w_mode_nxt   = next_mode(r_mode);
            w_led_nxt    = start_pattern(w_mode_nxt);
            w_dir_nxt    = DIR_RIGHT;
            w_phase_nxt  = PHASE_FILL;
            w_paused_nxt = 1'b0;
            w_cnt_nxt    = w_reload;
        end else begin
            if (w_tick) begin
                w_cnt_nxt = w_reload;
                case (r_mode)
                    BOUNCE: begin
                        if (!$onehot(r_led)) begin
                            w_led_nxt = START_BOUNCE;
                            w_dir_nxt = DIR_RIGHT;
                        end else if (r_led[0]) begin
                            w_dir_nxt = DIR_LEFT;
                            w_led_nxt = r_led << 1;
                        end else if (r_led[N_LED-1]) begin
                            w_dir_nxt = DIR_RIGHT;
                            w_led_nxt = r_led >> 1;
                        end else begin
                            w_led_nxt = (r_dir == DIR_LEFT) ? (r_led << 1) : (r_led >> 1);
                        end
                    end
                    CHASE: begin
                        if (!$onehot(r_led))
                            w_led_nxt = START_CHASE;
                        else
                            w_led_nxt = {r_led[N_LED-2:0], r_led[N_LED-1]};
                    end
                    FILL: begin
                        w_led_nxt = w_fill_shift;
                        if (r_phase == PHASE_FILL && (&w_fill_shift))
                            w_phase_nxt = PHASE_CLEAR;
                        else if (r_phase == PHASE_CLEAR && (w_fill_shift == '0))
                            w_phase_nxt = PHASE_FILL;
                    end
                    default: w_led_nxt = ~r_led;
                endcase
            end else if (!r_paused) begin
                w_cnt_nxt = r_tick_cnt - TICK_LOG2'(1);
            end

            // Resuming restarts the step period from a fresh reload.
            if (w_pause_press) begin
                w_paused_nxt = ~r_paused;
                if (r_paused)
                    w_cnt_nxt = w_reload;
            end
        end
    end

    assign io_led.LEDR   = r_led;
    assign io_led.MODE   = r_mode;
    assign io_led.PAUSED = r_paused;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: directed key/switch scenarios plus random key and
// switch activity, compared every cycle against a step-count reference model.
module tb_led_pattern_ctrl;

    localparam int TICK_LOG2    = 4;
    localparam int DEBOUNCE_CYC = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int errors = 0;
    int checks = 0;

    led_pattern_ctrl_if led_if ();

    led_pattern_ctrl #(
        .TICK_LOG2    (TICK_LOG2),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .io_led   (led_if)
    );

    always #5 clk = ~clk;

    // Reference state: the pattern is a pure function of (mode, steps since mode entry).
    int unsigned m_mode   = 0;
    int unsigned m_k      = 0;
    int unsigned m_wait   = 0;
    bit          m_paused = 1'b0;
    bit          raw_p1[2] = '{1'b1, 1'b1};
    bit          raw_p2[2] = '{1'b1, 1'b1};
    bit          level[2]  = '{1'b1, 1'b1};
    int          run_len[2] = '{0, 0};
    bit          pend[2]   = '{1'b0, 1'b0};

    function automatic logic [9:0] exp_led(input int unsigned mode, input int unsigned k);
        int unsigned j;
        case (mode)
            0: begin
                j = k % 18;
                return 10'(32'd1 << ((j <= 9) ? (9 - j) : (j - 9)));
            end
            1: return 10'(32'd1 << (k % 10));
            2: begin
                j = k % 20;
                if (j <= 10) return 10'((32'd1 << j) - 32'd1);
                else         return 10'((32'd1023 << (j - 10)) & 32'd1023);
            end
            default: return ((k % 2) == 0) ? 10'h3FF : 10'h000;
        endcase
    endfunction

    always @(posedge clk) begin
        bit          mp;
        bit          pp;
        bit          tick;
        bit          raw[2];
        int unsigned per;
        if (!rst_n) begin
            m_mode = 0; m_k = 0; m_wait = 0; m_paused = 1'b0;
            for (int i = 0; i < 2; i++) begin
                raw_p1[i] = 1'b1; raw_p2[i] = 1'b1; level[i] = 1'b1;
                run_len[i] = 0; pend[i] = 1'b0;
            end
        end else begin
            mp   = pend[0];
            pp   = pend[1];
            per  = 32'd1 << (TICK_LOG2 - int'(led_if.SW));
            tick = (m_wait == 0) && !m_paused;
            if (mp) begin
                m_mode = (m_mode + 1) % 4; m_k = 0; m_paused = 1'b0; m_wait = per - 1;
            end else begin
                if (tick) begin
                    m_k++; m_wait = per - 1;
                end else if (!m_paused) begin
                    m_wait--;
                end
                if (pp) begin
                    m_paused = !m_paused;
                    if (!m_paused) m_wait = per - 1;
                end
            end
            raw[0] = led_if.KEY_MODE;
            raw[1] = led_if.KEY_PAUSE;
            for (int i = 0; i < 2; i++) begin
                pend[i] = 1'b0;
                if (raw_p2[i] != level[i]) begin
                    run_len[i]++;
                    if (run_len[i] == DEBOUNCE_CYC) begin
                        level[i] = raw_p2[i]; run_len[i] = 0; pend[i] = !raw_p2[i];
                    end
                end else begin
                    run_len[i] = 0;
                end
                raw_p2[i] = raw_p1[i];
                raw_p1[i] = raw[i];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_eq("ledr",   32'(led_if.LEDR),   32'(exp_led(m_mode, m_k)));
        check_eq("mode",   32'(led_if.MODE),   m_mode);
        check_eq("paused", 32'(led_if.PAUSED), 32'(m_paused));
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_outputs();
        end
    endtask

    task automatic press(input bit on_mode, input bit on_pause, input int low_cycles);
        led_if.KEY_MODE  = on_mode  ? 1'b0 : 1'b1;
        led_if.KEY_PAUSE = on_pause ? 1'b0 : 1'b1;
        run_cycles(low_cycles);
        led_if.KEY_MODE  = 1'b1;
        led_if.KEY_PAUSE = 1'b1;
        run_cycles(DEBOUNCE_CYC + 4);
    endtask

    initial begin
        led_if.KEY_MODE  = 1'b1;
        led_if.KEY_PAUSE = 1'b1;
        led_if.SW        = 2'd0;
        rst_n            = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ledr",   32'(led_if.LEDR),   32'h200);
        check_eq("rst_mode",   32'(led_if.MODE),   32'd0);
        check_eq("rst_paused", 32'(led_if.PAUSED), 32'd0);
        rst_n = 1'b1;

        // Bounce at SW=0: first step one cycle after release, then every 16 cycles.
        run_cycles(1 + 8 * 16);
        check_eq("bounce_bit0", 32'(led_if.LEDR), 32'h001);
        run_cycles(16);
        check_eq("bounce_back", 32'(led_if.LEDR), 32'h002);
        run_cycles(40);

        led_if.SW = 2'd3;
        run_cycles(40);
        led_if.SW = 2'd1;
        run_cycles(21);

        led_if.SW = 2'd3;
        press(1'b1, 1'b0, 6);
        check_eq("mode_chase", 32'(led_if.MODE), 32'd1);
        run_cycles(30);
        press(1'b1, 1'b0, 3);
        check_eq("glitch_ignored", 32'(led_if.MODE), 32'd1);

        press(1'b1, 1'b0, 6);
        check_eq("mode_fill", 32'(led_if.MODE), 32'd2);
        run_cycles(50);

        press(1'b0, 1'b1, 6);
        check_eq("paused_on", 32'(led_if.PAUSED), 32'd1);
        run_cycles(100);
        press(1'b0, 1'b1, 6);
        check_eq("paused_off", 32'(led_if.PAUSED), 32'd0);
        run_cycles(25);

        press(1'b0, 1'b1, 6);
        press(1'b1, 1'b1, 6);
        check_eq("both_mode",   32'(led_if.MODE),   32'd3);
        check_eq("both_paused", 32'(led_if.PAUSED), 32'd0);
        run_cycles(10);

        for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 5);
        run_cycles(15);
        rst_n = 1'b0;
        run_cycles(2);
        check_eq("rst_fill_ledr", 32'(led_if.LEDR), 32'h200);
        check_eq("rst_fill_mode", 32'(led_if.MODE), 32'd0);
        rst_n = 1'b1;

        // A key released by reset before debounce completes must not register.
        led_if.KEY_MODE = 1'b0;
        run_cycles(4);
        rst_n = 1'b0;
        led_if.KEY_MODE = 1'b1;
        run_cycles(2);
        rst_n = 1'b1;
        run_cycles(12);
        check_eq("rst_mid_debounce", 32'(led_if.MODE), 32'd0);

        for (int it = 0; it < 120; it++) begin
            led_if.SW        = 2'($urandom_range(0, 3));
            led_if.KEY_MODE  = ($urandom_range(0, 3) != 0);
            led_if.KEY_PAUSE = ($urandom_range(0, 2) != 0);
            rst_n            = ($urandom_range(0, 39) != 0);
            run_cycles($urandom_range(1, 9));
            rst_n = 1'b1;
        end
        led_if.KEY_MODE  = 1'b1;
        led_if.KEY_PAUSE = 1'b1;
        run_cycles(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
